pifo_push_arbiter: RTL and testbench

PIFO_PUSH_ARBITER -- requirements
Module: pifo_push_arbiter

---
 rtl/pifo_push_arbiter_if.sv | 29 ++
 rtl/pifo_push_arbiter.sv | 112 +++++++++++
 tb/tb_pifo_push_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pifo_push_arbiter_if.sv
// Requester enqueue bus plus PIFO enqueue/dequeue bus of the PIFO push arbiter.
// master = arbiter side, slave = requesters together with the PIFO.
interface pifo_push_arbiter_if #(
   parameter int REQS  = 4,
   parameter int FLOWS = 10
);
   logic [REQS-1:0]       req_valid;
   logic [REQS-1:0]       req_ready;
   logic [32*REQS-1:0]    req_rank;
   logic [32*REQS-1:0]    req_value;
   logic [FLOWS*REQS-1:0] req_flow;
   logic                  push;
   logic [31:0]           push_rank;
   logic [31:0]           push_value;
   logic [FLOWS-1:0]      push_flow;
   logic                  pop;
   logic                  pop_valid;
   logic [31:0]           pop_value;

   modport master (
      input  req_valid, req_rank, req_value, req_flow, pop_valid, pop_value,
      output req_ready, push, push_rank, push_value, push_flow, pop
   );

   modport slave (
      output req_valid, req_rank, req_value, req_flow, pop_valid, pop_value,
      input  req_ready, push, push_rank, push_value, push_flow, pop
   );
endinterface

// File: rtl/pifo_push_arbiter.sv
// Round-robin enqueue arbiter for a PIFO with occupancy tracking and flush drain; PIFO_ARB_STATS_EN adds push/pop counters.
// Latency: grant->push 1 cycle, pop combinational; backpressure: no grants at capacity or while draining.
module pifo_push_arbiter #(
   parameter int REQS     = 4,
   parameter int FLOWS    = 10,
   parameter int CAPACITY = 500
) (
   input  logic                          clk,
   input  logic                          rst,
   pifo_push_arbiter_if.master           bus,
   input  logic                          deq_req,
   output logic                          deq_valid,
   output logic [31:0]                   deq_value,
   input  logic                          flush,
   output logic                          busy,
   output logic [$clog2(CAPACITY+1)-1:0] occupancy,
   output logic                          full
`ifdef PIFO_ARB_STATS_EN
   ,
   output logic [31:0]                   push_total,
   output logic [31:0]                   pop_total
`endif
);
   localparam int IDX_W = (REQS > 1) ? $clog2(REQS) : 1;
   localparam int OCC_W = $clog2(CAPACITY + 1);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] gnt_idx;
   logic [IDX_W-1:0] cand;
   logic             gnt_found;
   logic             grant_ok;
   logic             hs;
   logic             occ_inc;
   logic             occ_dec;

   // First valid requester at or after rr_ptr, wrapping REQS-1 -> 0.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < REQS; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % REQS);
         if (!gnt_found && bus.req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // The in-flight push counts against capacity so the PIFO never overfills.
   assign grant_ok = rst && (state == RUN) &&
                     ((int'(occupancy) + int'(bus.push)) < CAPACITY);

   assign hs            = grant_ok && gnt_found;
   assign bus.req_ready = hs ? (REQS'(1) << gnt_idx) : '0;
   assign bus.pop       = rst && (deq_req || (state == DRAIN)) && (occupancy != '0);
   assign deq_valid     = rst && bus.pop_valid && (state == RUN);
   assign deq_value     = bus.pop_value;
   assign busy          = (state == DRAIN);
   assign full          = (occupancy == OCC_W'(CAPACITY));

   assign occ_inc = bus.push && !bus.pop_valid && (occupancy != OCC_W'(CAPACITY));
   assign occ_dec = bus.pop_valid && !bus.push && (occupancy != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= RUN;
         rr_ptr         <= '0;
         occupancy      <= '0;
         bus.push       <= 1'b0;
         bus.push_rank  <= '0;
         bus.push_value <= '0;
         bus.push_flow  <= '0;
      end else begin
         bus.push <= hs;
         if (hs) begin
            bus.push_rank  <= bus.req_rank[32*gnt_idx +: 32];
            bus.push_value <= bus.req_value[32*gnt_idx +: 32];
            bus.push_flow  <= bus.req_flow[FLOWS*gnt_idx +: FLOWS];
            rr_ptr         <= (gnt_idx == IDX_W'(REQS - 1)) ? '0 : gnt_idx + 1'b1;
         end

         if (occ_inc) begin
            occupancy <= occupancy + 1'b1;
         end else if (occ_dec) begin
            occupancy <= occupancy - 1'b1;
         end

         // Stay in DRAIN until a late push from the flush cycle has also been popped.
         case (state)
            RUN:     if (flush) state <= DRAIN;
            DRAIN:   if ((occupancy == '0) && !bus.push && !flush) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

`ifdef PIFO_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         push_total <= '0;
         pop_total  <= '0;
      end else begin
         if (bus.push)      push_total <= push_total + 32'd1;
         if (bus.pop_valid) pop_total  <= pop_total + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_pifo_push_arbiter.sv
// Directed bench for pifo_push_arbiter: round-robin order, capacity stall, occupancy, flush drain, async reset, counters.
// A small FIFO stands in for the PIFO; expected pushes and dequeues are queued as stimulus is driven.
module tb_pifo_push_arbiter;
   localparam int REQS = 4;
   localparam int FLOWS = 10;
   localparam int CAP = 500;
   localparam int OW = $clog2(CAP + 1);
   localparam int OW4 = $clog2(4 + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic deq_req, flush, spur;
   logic deq_valid, busy, full;
   logic [31:0] deq_value;
   logic [OW-1:0] occupancy;
   logic deq_valid4, busy4, full4;
   logic [31:0] deq_value4;
   logic [OW4-1:0] occupancy4;
`ifdef PIFO_ARB_STATS_EN
   logic [31:0] push_total, pop_total, push_total4, pop_total4;
`endif

   int checks = 0;
   int errors = 0;
   int push_cnt4 = 0;
   int unsigned tag = 0;
   logic [31:0] exp_push[$];
   int exp_idx[$];
   logic [31:0] exp_deq[$];

   pifo_push_arbiter_if #(.REQS(REQS), .FLOWS(FLOWS)) bus ();
   pifo_push_arbiter_if #(.REQS(REQS), .FLOWS(FLOWS)) bus4 ();

   always #5 clk = ~clk;

   pifo_push_arbiter #(.REQS(REQS), .FLOWS(FLOWS), .CAPACITY(CAP)) dut (
      .clk(clk), .rst(rst), .bus(bus), .deq_req(deq_req), .deq_valid(deq_valid),
      .deq_value(deq_value), .flush(flush), .busy(busy), .occupancy(occupancy), .full(full)
`ifdef PIFO_ARB_STATS_EN
      , .push_total(push_total), .pop_total(pop_total)
`endif
   );

   pifo_push_arbiter #(.REQS(REQS), .FLOWS(FLOWS), .CAPACITY(4)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4), .deq_req(1'b0), .deq_valid(deq_valid4),
      .deq_value(deq_value4), .flush(1'b0), .busy(busy4), .occupancy(occupancy4), .full(full4)
`ifdef PIFO_ARB_STATS_EN
      , .push_total(push_total4), .pop_total(pop_total4)
`endif
   );

   // Capacity-4 instance: requester 2 always requesting, nothing ever dequeued.
   assign bus4.req_valid = 4'b0100;
   assign bus4.req_rank  = '0;
   assign bus4.req_value = '0;
   assign bus4.req_flow  = '0;
   assign bus4.pop_valid = 1'b0;
   assign bus4.pop_value = '0;

   // FIFO stand-in for the PIFO on the main instance.
   logic [31:0] mem [0:63];
   logic [5:0] wp, rp;
   assign bus.pop_valid = bus.pop | spur;
   assign bus.pop_value = mem[rp];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (bus.push) begin
            mem[wp] <= bus.push_value;
            wp <= wp + 6'd1;
         end
         if (bus.pop_valid && (rp != wp)) rp <= rp + 6'd1;
      end
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, want);
      end
   endtask

   function automatic logic [31:0] req_val(input int i);
      return 32'hC0DE_0000 + 32'(tag * 16 + i);
   endfunction

   task automatic drive_req(input logic [REQS-1:0] v);
      tag++;
      bus.req_valid = v;
      for (int i = 0; i < REQS; i++) begin
         bus.req_rank[32*i +: 32]       = 32'(tag * 16 + i);
         bus.req_value[32*i +: 32]      = req_val(i);
         bus.req_flow[FLOWS*i +: FLOWS] = FLOWS'(1) << i;
      end
   endtask

   task automatic expect_grant(input int idx);
      check("req_ready", 32'(bus.req_ready), 32'(1) << idx);
      exp_push.push_back(req_val(idx));
      exp_idx.push_back(idx);
      exp_deq.push_back(req_val(idx));
   endtask

   task automatic expect_pop(input bit run);
      logic [31:0] v;
      v = '0;
      if (exp_deq.size() != 0) v = exp_deq.pop_front();
      check("pop", 32'(bus.pop), 32'd1);
      check("deq_valid", 32'(deq_valid), 32'(run));
      if (run) check("deq_value", deq_value, v);
   endtask

   // One clock step; the push scoreboard is compared at every falling edge.
   task automatic cyc();
      logic [31:0] v;
      int idx;
      @(negedge clk);
      if (bus4.push) push_cnt4++;
      check("push", 32'(bus.push), 32'(exp_push.size() != 0));
      if (exp_push.size() != 0) begin
         v = exp_push.pop_front();
         idx = exp_idx.pop_front();
         if (bus.push) begin
            check("push_value", bus.push_value, v);
            check("push_rank", bus.push_rank, v - 32'hC0DE_0000);
            check("push_flow", 32'(bus.push_flow), 32'(1) << idx);
         end
      end
   endtask

   initial begin
      deq_req = 1'b1;
      flush = 1'b0;
      spur = 1'b1;
      drive_req('1);
      repeat (3) begin
         cyc();
         #1;
         check("rst_req_ready", 32'(bus.req_ready), 0);
         check("rst_pop", 32'(bus.pop), 0);
         check("rst_deq_valid", 32'(deq_valid), 0);
         check("rst_occ", 32'(occupancy), 0);
         check("rst_push_value", bus.push_value, 0);
         check("rst_busy", 32'(busy), 0);
      end

      // Round-robin with all requesters valid.
      cyc();
      rst = 1'b1;
      deq_req = 1'b0;
      spur = 1'b0;
      drive_req('0);
      for (int k = 0; k < 8; k++) begin
         cyc();
         drive_req('1);
         #1;
         expect_grant(k % 4);
      end
      cyc();
      drive_req('0);
      #1;
      check("idle_ready", 32'(bus.req_ready), 0);
      cyc();
      check("occ_8", 32'(occupancy), 8);
      check("full_main", 32'(full), 0);
      check("cap4_pushes", push_cnt4, 4);
      check("cap4_full", 32'(full4), 1);
      check("cap4_occ", 32'(occupancy4), 4);
      check("cap4_ready", 32'(bus4.req_ready), 0);

      // Dequeue down to 3, then push and pop_valid in the same cycle.
      for (int k = 0; k < 5; k++) begin
         cyc();
         deq_req = 1'b1;
         #1;
         expect_pop(1'b1);
      end
      cyc();
      deq_req = 1'b0;
      #1;
      check("pop_idle", 32'(bus.pop), 0);
      check("occ_3", 32'(occupancy), 3);
      cyc();
      drive_req(4'b0100);
      #1;
      expect_grant(2);
      cyc();
      drive_req('0);
      deq_req = 1'b1;
      #1;
      expect_pop(1'b1);
      cyc();
      deq_req = 1'b0;
      check("occ_same", 32'(occupancy), 3);
      check("cap4_hold_ready", 32'(bus4.req_ready), 0);
      check("cap4_hold_pushes", push_cnt4, 4);

      // Fill to 5 and flush.
      drive_req('1);
      #1;
      expect_grant(3);
      cyc();
      drive_req('1);
      #1;
      expect_grant(0);
      cyc();
      drive_req('0);
      cyc();
      check("occ_5", 32'(occupancy), 5);
      flush = 1'b1;
      #1;
      check("flush_busy0", 32'(busy), 0);
      check("flush_pop0", 32'(bus.pop), 0);
      cyc();
      flush = 1'b0;
      drive_req('1);
      #1;
      check("drain_busy", 32'(busy), 1);
      check("drain_ready", 32'(bus.req_ready), 0);
      expect_pop(1'b0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         #1;
         check("drain_ready", 32'(bus.req_ready), 0);
         expect_pop(1'b0);
      end
      cyc();
      #1;
      check("drain_pop_done", 32'(bus.pop), 0);
      check("drain_busy_tail", 32'(busy), 1);

      // Grants resume; a grant on the flush cycle is pushed and drained.
      cyc();
      flush = 1'b1;
      drive_req('1);
      #1;
      check("resume_busy", 32'(busy), 0);
      check("resume_occ", 32'(occupancy), 0);
      expect_grant(1);
      cyc();
      flush = 1'b0;
      #1;
      check("late_busy", 32'(busy), 1);
      check("late_ready", 32'(bus.req_ready), 0);
      check("late_pop0", 32'(bus.pop), 0);
      cyc();
      #1;
      check("late_busy2", 32'(busy), 1);
      expect_pop(1'b0);
      cyc();
      #1;
      check("late_busy3", 32'(busy), 1);
      check("late_pop_done", 32'(bus.pop), 0);
      cyc();
      #1;
      check("late_busy_clear", 32'(busy), 0);
      expect_grant(2);
      cyc();
      drive_req('0);

      // Normal dequeue, then a spurious pop_valid at occupancy 0.
      cyc();
      deq_req = 1'b1;
      #1;
      expect_pop(1'b1);
      cyc();
      deq_req = 1'b0;
      spur = 1'b1;
      #1;
      check("spur_pop", 32'(bus.pop), 0);
      check("spur_deq_valid", 32'(deq_valid), 1);
      cyc();
      spur = 1'b0;
      check("spur_occ", 32'(occupancy), 0);

      // Fill to 7 and reset asynchronously mid-stream.
      for (int k = 0; k < 8; k++) begin
         if (k != 0) cyc();
         drive_req('1);
         #1;
         expect_grant((k + 3) % 4);
      end
      cyc();
      check("occ_7", 32'(occupancy), 7);
      #2;
      rst = 1'b0;
      #1;
      check("arst_occ", 32'(occupancy), 0);
      check("arst_push", 32'(bus.push), 0);
      check("arst_ready", 32'(bus.req_ready), 0);
      check("arst_push_value", bus.push_value, 0);
      exp_deq.delete();
      cyc();
      rst = 1'b1;
      drive_req('0);
      cyc();
      drive_req('1);
      #1;
      check("post_rst_busy", 32'(busy), 0);

      // rr_ptr restarts at 0; ten pushes and four pops.
      for (int k = 0; k < 10; k++) begin
         if (k != 0) begin
            cyc();
            drive_req('1);
            #1;
         end
         expect_grant(k % 4);
      end
      cyc();
      drive_req('0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         deq_req = 1'b1;
         #1;
         expect_pop(1'b1);
      end
      cyc();
      deq_req = 1'b0;
      check("occ_6", 32'(occupancy), 6);
`ifdef PIFO_ARB_STATS_EN
      check("push_total", push_total, 10);
      check("pop_total", pop_total, 4);
`endif
      cyc();
      check("push_queue_empty", 32'(exp_push.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
